// File: rtl/div_pkg.sv
// Shared definitions for the sequential 4-bit restoring divider.
//   state_t   : controller state encoding (IDLE / CALC / DONE)
//   W, ITER   : operand width and number of quotient-bit iterations
//   DBZ_QUOT  : quotient reported for a divide-by-zero request
package div_pkg;
  localparam int W    = 4;
  localparam int ITER = 4;

  localparam logic [W-1:0] DBZ_QUOT = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/fourbit_subtractor.sv
// Combinational 4-bit subtractor with borrow.
//   x, y  : minuend, subtrahend
//   bin   : borrow in
//   diff  : x - y - bin (mod 16)
//   bout  : borrow out, set when x < y + bin
module fourbit_subtractor (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bin,
  output logic [3:0] diff,
  output logic       bout
);
  logic [4:0] t;

  assign t    = {1'b0, x} - {1'b0, y} - {4'b0000, bin};
  assign diff = t[3:0];
  assign bout = t[4];
endmodule

// File: rtl/seq_divider4_ctrl.sv
// Sequential restoring divider, 4-bit unsigned operands. One shared
// fourbit_subtractor performs one trial subtraction per quotient bit.
//   clk, rst            : clock, synchronous active-high reset
//   start               : request, sampled only while ready
//   dividend, divisor   : operands, captured on an accepted start
//   ready / busy / done : IDLE / CALC / DONE state indications
//   quotient, remainder : results, updated on entry to DONE and held
//   dbz                 : divide-by-zero flag, valid with done
module seq_divider4_ctrl #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         dbz
);
  import div_pkg::*;

  state_t       state, state_n;
  logic [1:0]   cnt;
  logic [W-1:0] r, q, d;
  logic [W-1:0] s, diff, r_n, q_n;
  logic         bout;

  // Shift the next dividend bit into the partial remainder, then try D.
  assign s = {r[W-2:0], q[W-1]};

  fourbit_subtractor u_sub (
    .x    (s),
    .y    (d),
    .bin  (1'b0),
    .diff (diff),
    .bout (bout)
  );

  // bout doubles as "S < D": restore on borrow, keep the difference otherwise.
  assign r_n = bout ? s : diff;
  assign q_n = {q[W-2:0], ~bout};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (divisor == '0) ? DONE : CALC;
      CALC:    if (cnt == 2'd0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign ready = (state == IDLE);
  assign busy  = (state == CALC);
  assign done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      r         <= '0;
      q         <= '0;
      d         <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (divisor != '0) begin
            r   <= '0;
            q   <= dividend;
            d   <= divisor;
            cnt <= 2'(ITER - 1);
            dbz <= 1'b0;
          end else begin
            // Divide by zero bypasses the datapath entirely.
            quotient  <= DBZ_QUOT;
            remainder <= dividend;
            dbz       <= 1'b1;
          end
        end
        CALC: begin
          r   <= r_n;
          q   <= q_n;
          cnt <= cnt - 2'd1;
          // Last iteration: publish the freshly computed values so the
          // results are valid in the same cycle done is high.
          if (cnt == 2'd0) begin
            quotient  <= q_n;
            remainder <= r_n;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider4_ctrl.sv
module tb_seq_divider4_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend, divisor;
  logic       ready, busy, done, dbz;
  logic [3:0] quotient, remainder;

  always #5 clk = ~clk;

  seq_divider4_ctrl #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  typedef struct {
    logic [3:0] a, b;
    logic [3:0] q, r;
    logic       z;
    int         lat;
  } vec_t;

  typedef struct {
    logic [3:0] q, r;
    logic       z;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] a, input logic [3:0] b);
    vec_t v;
    v.a = a; v.b = b;
    if (b == 4'd0) begin
      v.q = 4'hF; v.r = a; v.z = 1'b1; v.lat = 1;
    end else begin
      v.q = a / b; v.r = a % b; v.z = 1'b0; v.lat = 5;
    end
    return v;
  endfunction

  // Drive one request, pop/compare its scoreboard entry when done shows up.
  // poke: pulse a second start (15/5) while busy; it must be ignored.
  task automatic run_div(input vec_t v, input bit poke, input string nm);
    int   lat;
    bit   seen;
    exp_t e;
    lat = 0;
    while (!ready && lat < 20) begin @(negedge clk); lat++; end
    if (!ready) begin
      chk({nm, " ready timeout"}, 0, 1);
      return;
    end
    dividend = v.a; divisor = v.b; start = 1'b1;
    @(posedge clk);
    e.q = v.q; e.r = v.r; e.z = v.z;
    sb.push_back(e);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 12) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        dividend = 4'($urandom); divisor = 4'($urandom);
      end
      if (poke && lat == 2) begin dividend = 4'd15; divisor = 4'd5; start = 1'b1; end
      if (poke && lat == 3) start = 1'b0;
      if (lat == 1 && v.lat == 5) chk({nm, " busy"}, busy, 1);
      if (done) seen = 1'b1;
    end
    chk({nm, " latency"}, seen ? lat : -1, v.lat);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      if (quotient !== e.q || remainder !== e.r || dbz !== e.z) begin
        tests++; fails++;
        $display("FAIL %s result: got q=%0d r=%0d dbz=%0d expected q=%0d r=%0d dbz=%0d",
                 nm, quotient, remainder, dbz, e.q, e.r, e.z);
      end else tests++;
    end else if (!seen) sb.delete();
    @(negedge clk);
    chk({nm, " done width"}, done, 0);
  endtask

  initial begin
    int   ndone, last, c;
    start = 1'b0; dividend = '0; divisor = '0; rst = 1'b1;

    vecs.push_back(mk(4'd13, 4'd4));
    vecs.push_back(mk(4'd7,  4'd0));
    vecs.push_back(mk(4'd15, 4'd1));
    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 16; b++)
        vecs.push_back(mk(4'(a), 4'(b)));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ready", ready, 1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset dbz", dbz, 0);
    rst = 1'b0;

    foreach (vecs[i]) run_div(vecs[i], 1'b0, $sformatf("vec%0d %0d/%0d", i, vecs[i].a, vecs[i].b));

    // Request while busy is dropped; results hold afterwards.
    run_div(mk(4'd3, 4'd9), 1'b1, "ignore 3/9");
    repeat (3) @(negedge clk);
    chk("hold quotient", quotient, 0);
    chk("hold remainder", remainder, 3);
    chk("hold done", done, 0);

    // Reset two cycles into 14/3.
    dividend = 4'd14; divisor = 4'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst ready", ready, 1);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst quotient", quotient, 0);
    chk("midrst remainder", remainder, 0);
    chk("midrst dbz", dbz, 0);
    ndone = 0;
    repeat (8) begin @(negedge clk); if (done) ndone++; end
    chk("midrst no done", ndone, 0);
    run_div(mk(4'd14, 4'd3), 1'b0, "after rst 14/3");

    // Reset together with start in IDLE, and reset during DONE.
    dividend = 4'd9; divisor = 4'd0; start = 1'b1; rst = 1'b1;
    @(negedge clk); start = 1'b0; rst = 1'b0;
    chk("rst+start ready", ready, 1);
    chk("rst+start dbz", dbz, 0);
    dividend = 4'd9; divisor = 4'd0; start = 1'b1;
    @(negedge clk); start = 1'b0; rst = 1'b1;
    chk("dbz done before rst", done, 1);
    @(negedge clk); rst = 1'b0;
    chk("rst in DONE quotient", quotient, 0);
    chk("rst in DONE ready", ready, 1);

    // Start held high: one result every 6 cycles.
    dividend = 4'd9; divisor = 4'd2; start = 1'b1;
    ndone = 0; last = -100;
    for (c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (last >= 0) chk("b2b period", c - last, 6);
        last = c;
        chk("b2b quotient", quotient, 4);
        chk("b2b remainder", remainder, 1);
      end
    end
    start = 1'b0;
    chk("b2b count", ndone, 5);
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
